dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
Parametrised data memory for the RV32I core. Adds a request/grant/response handshake, a configurable wait-state count, byte-enable stores and load extension. Sits between the core's dmem port and the on-chip data array in top. Supports multi-cycle memory timing in place of the fixed zero-latency model.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, at least 4).
WAIT_STATES, 1, extra cycles between accept and response (0..15).
INIT_FILE, "", hex image loaded by $readmemh at elaboration when non-empty.

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
dmem_req  in  1  request valid
dmem_gnt  out  1  request accepted this cycle when dmem_req && dmem_gnt
dmem_wr_en  in  1  1 = store, 0 = load
dmem_size  in  mem_size_t  MEM_BYTE / MEM_HALF / MEM_WORD
dmem_zero_extend  in  1  load: 1 = zero-extend, 0 = sign-extend
dmem_addr  in  32  byte address
dmem_wr_data  in  32  store data, right-aligned (bits [7:0] for byte)
dmem_rsp_valid  out  1  one-cycle completion pulse for load or store
dmem_rd_data  out  32  extended load data, valid with dmem_rsp_valid
dmem_err  out  1  access fault, valid with dmem_rsp_valid

Behaviour:
- Clock is clk. Reset is reset_n, asynchronous, active-low. Reset drives state to IDLE, the wait counter to 0, dmem_rsp_valid to 0, dmem_err to 0 and dmem_rd_data to 0. Array contents are not reset.
- FSM states are IDLE, WAIT and RESP.
- dmem_gnt = 1 in IDLE and in RESP, 0 in WAIT.
- On accept, latch wr_en, size, zero_extend, addr and wr_data. Next state is WAIT with the counter set to WAIT_STATES-1 if WAIT_STATES > 0; otherwise RESP.
- WAIT: decrement the counter each cycle. Move to RESP on the cycle the counter reaches 0.
- Entering RESP, on that clock edge:
  - Stores write the array with byte enables.
  - Loads sample the word.
  - dmem_rsp_valid is 1 for exactly that RESP cycle.
- Latency: a request accepted in cycle T responds in cycle T+1+WAIT_STATES.
- RESP with a new accept: go to WAIT or RESP again, for back-to-back transfers. RESP without a new accept: go to IDLE.
- Peak throughput is one access per 1+WAIT_STATES cycles.
- Byte enables are set by size and addr[1:0]:
  - byte: 1 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
  - Store data is replicated across lanes before masking.
- Loads select the lane by addr[1:0], then sign- or zero-extend from bit 7 (byte) or bit 15 (half). Word loads are passed through unchanged.
- Word index is addr[$clog2(DEPTH_WORDS)+1:2].
- A load issued after a store to the same word, back-to-back, returns the new data.
- dmem_rd_data holds its value outside RESP. It is 0 after a store response.
- Reset mid-transfer drops the pending request. A store whose RESP edge has not occurred is not written.
- dmem_req while dmem_gnt = 0 is ignored. The requester must hold its request until granted.

Optional Feature:
Macro DMEM_ACCESS_CHECK_EN.
- Defined:
  - Misaligned accesses raise dmem_err with dmem_rsp_valid, at normal latency. Misaligned means a half at addr[0]=1, or a word with addr[1:0] != 0.
  - Out-of-range accesses raise dmem_err the same way. Out-of-range means addr >= DEPTH_WORDS*4.
  - A faulted store does not write. A faulted load returns dmem_rd_data = 0.
- Not defined:
  - dmem_err is tied to 0.
  - Upper address bits are ignored, so the address wraps modulo the array size.
  - Misaligned halves and words are aligned down, with offsets forced to 0 for that size.

Decomposition:
- riscv_pkg already holds mem_size_t. Add dmem_state_t (IDLE, WAIT, RESP) and the constant DMEM_MAX_WAIT = 15 there.
- One combinational sub-module, dmem_lane_align, generates byte enables, replicates store data, and selects and extends load lanes.
- The FSM, counter and array stay in dmem_ctrl.

Test Plan:
- WAIT_STATES=2. Store word 0xDEADBEEF at 0x10, accepted at cycle 5 -> rsp_valid at cycle 8, err=0. Load word 0x10 -> rd_data 0xDEADBEEF, three cycles after its accept.
- Store byte 0x80 at 0x13, then load byte 0x13 with sign-extend -> 0xFFFFFF80. Zero-extend -> 0x00000080. Load word 0x10 -> 0x80ADBEEF.
- WAIT_STATES=0. Store half 0x1234 at 0x22, accepted in the RESP cycle, then load half 0x22 -> rd_data 0x00001234. Data appears one cycle after each accept, with gnt continuously 1.
- dmem_req held during WAIT -> dmem_gnt=0 and no second accept until RESP. Request fields changed during WAIT do not alter the in-flight access.
- reset_n low in WAIT of a store to 0x40 -> rsp_valid never asserts and word 0x40 is unchanged. The next load returns the prior value.
- With DMEM_ACCESS_CHECK_EN: word store at 0x41 -> err=1 and no write. Load at DEPTH_WORDS*4 -> err=1, rd_data=0. Without the macro: the same store writes word 0x40.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I types: memory access sizes and data-memory controller states.
package riscv_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int unsigned DMEM_MAX_WAIT = 15;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for dmem_ctrl: store byte enables and data replication,
// load lane selection with sign/zero extension. Purely combinational.
module dmem_lane_align
  import riscv_pkg::*;
(
  input  mem_size_t   size,
  input  logic        zero_extend,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_data_rep,
  output logic [31:0] rd_data
);

  logic [1:0]  offset;
  logic [31:0] shifted;

  always_comb begin
    offset      = '0;
    byte_en     = '1;
    wr_data_rep = wr_data;
    rd_data     = '0;
    // Misaligned halves/words are aligned down by forcing the low offset bits.
    case (size)
      MEM_BYTE: begin
        offset      = addr_lo;
        byte_en     = 4'b0001 << addr_lo;
        wr_data_rep = {4{wr_data[7:0]}};
      end
      MEM_HALF: begin
        offset      = {addr_lo[1], 1'b0};
        byte_en     = 4'b0011 << offset;
        wr_data_rep = {2{wr_data[15:0]}};
      end
      default: begin
        offset      = '0;
        byte_en     = '1;
        wr_data_rep = wr_data;
      end
    endcase

    shifted = rd_word >> {offset, 3'b000};
    case (size)
      MEM_BYTE: rd_data = {{24{~zero_extend & shifted[7]}}, shifted[7:0]};
      MEM_HALF: rd_data = {{16{~zero_extend & shifted[15]}}, shifted[15:0]};
      default:  rd_data = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory with req/gnt/response handshake and WAIT_STATES extra latency.
// Optional DMEM_ACCESS_CHECK_EN: misaligned/out-of-range accesses raise dmem_err.
module dmem_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dmem_req,
  output logic        dmem_gnt,
  input  logic        dmem_wr_en,
  input  mem_size_t   dmem_size,
  input  logic        dmem_zero_extend,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wr_data,
  output logic        dmem_rsp_valid,
  output logic [31:0] dmem_rd_data,
  output logic        dmem_err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dmem_state_t state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        accept, enter_resp;

  logic        lat_wr, lat_zx;
  mem_size_t   lat_size;
  logic [31:0] lat_addr, lat_wdata;

  logic        op_wr, op_zx, op_fault;
  mem_size_t   op_size;
  logic [31:0] op_addr, op_wdata;
  logic [AW-1:0] op_idx;

  logic [3:0]  byte_en;
  logic [31:0] wdata_rep, load_data;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    dmem_gnt   = (state != WAIT);
    accept     = dmem_req && dmem_gnt;
    case (state)
      WAIT: begin
        if (cnt == '0) state_next = RESP;
        else           cnt_next   = cnt - 4'd1;
      end
      default: begin
        if (accept) begin
          state_next = (WAIT_STATES > 0) ? WAIT : RESP;
          cnt_next   = CNT_INIT;
        end else begin
          state_next = IDLE;
        end
      end
    endcase
    // Gating on reset_n keeps a request held during reset from writing.
    enter_resp = (state_next == RESP) && reset_n;
  end

  // With zero wait states the access completes on its accept edge, before the latch.
  always_comb begin
    if (state == WAIT) begin
      op_wr    = lat_wr;
      op_zx    = lat_zx;
      op_size  = lat_size;
      op_addr  = lat_addr;
      op_wdata = lat_wdata;
    end else begin
      op_wr    = dmem_wr_en;
      op_zx    = dmem_zero_extend;
      op_size  = dmem_size;
      op_addr  = dmem_addr;
      op_wdata = dmem_wr_data;
    end
    op_idx = op_addr[AW+1:2];
  end

`ifdef DMEM_ACCESS_CHECK_EN
  always_comb begin
    op_fault = (op_addr >> (AW + 2)) != '0;
    case (op_size)
      MEM_BYTE: ;
      MEM_HALF: if (op_addr[0]) op_fault = 1'b1;
      default:  if (op_addr[1:0] != 2'b00) op_fault = 1'b1;
    endcase
  end
`else
  logic unused_addr_bits;
  assign op_fault         = 1'b0;
  assign unused_addr_bits = ^op_addr;
`endif

  dmem_lane_align u_lane_align (
    .size        (op_size),
    .zero_extend (op_zx),
    .addr_lo     (op_addr[1:0]),
    .wr_data     (op_wdata),
    .rd_word     (mem[op_idx]),
    .byte_en     (byte_en),
    .wr_data_rep (wdata_rep),
    .rd_data     (load_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      lat_wr         <= 1'b0;
      lat_zx         <= 1'b0;
      lat_size       <= MEM_BYTE;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      dmem_rsp_valid <= 1'b0;
      dmem_rd_data   <= '0;
      err_q          <= 1'b0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      dmem_rsp_valid <= enter_resp;
      err_q          <= enter_resp && op_fault;
      if (accept) begin
        lat_wr    <= dmem_wr_en;
        lat_zx    <= dmem_zero_extend;
        lat_size  <= dmem_size;
        lat_addr  <= dmem_addr;
        lat_wdata <= dmem_wr_data;
      end
      if (enter_resp) dmem_rd_data <= (op_wr || op_fault) ? '0 : load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (enter_resp && op_wr && !op_fault) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[op_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  assign dmem_err = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: two instances (2 and 0 wait states).
// Expectations follow DMEM_ACCESS_CHECK_EN when it is defined.
module tb_dmem_ctrl;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  logic        req2, gnt2, wr2, zx2, rv2, err2;
  mem_size_t   size2;
  logic [31:0] addr2, wdata2, rd2;

  logic        req0, gnt0, wr0, zx0, rv0, err0;
  mem_size_t   size0;
  logic [31:0] addr0, wdata0, rd0;

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH_WORDS(64), .WAIT_STATES(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .dmem_req(req2), .dmem_gnt(gnt2),
    .dmem_wr_en(wr2), .dmem_size(size2), .dmem_zero_extend(zx2),
    .dmem_addr(addr2), .dmem_wr_data(wdata2), .dmem_rsp_valid(rv2),
    .dmem_rd_data(rd2), .dmem_err(err2)
  );

  dmem_ctrl #(.DEPTH_WORDS(64), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .dmem_req(req0), .dmem_gnt(gnt0),
    .dmem_wr_en(wr0), .dmem_size(size0), .dmem_zero_extend(zx0),
    .dmem_addr(addr0), .dmem_wr_data(wdata0), .dmem_rsp_valid(rv0),
    .dmem_rd_data(rd0), .dmem_err(err0)
  );

  // Drives one transfer on the 2-wait instance; called just after a posedge.
  task automatic txn2(input logic wr, input mem_size_t sz, input logic zx,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
    int n = 0;
    wr2 = wr; size2 = sz; zx2 = zx; addr2 = a; wdata2 = d; req2 = 1'b1;
    while (!gnt2 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req2 = 1'b0;
    lat = 1;
    while (!rv2 && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = rd2;
    er = err2;
  endtask

  task automatic test_reset();
    checks++; if (rv2 !== 1'b0) begin errors++; $display("FAIL reset_rv2 got %b want 0", rv2); end
    checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL reset_rd2 got %h want 00000000", rd2); end
    checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL reset_err2 got %b want 0", err2); end
    checks++; if (gnt2 !== 1'b1) begin errors++; $display("FAIL reset_gnt2 got %b want 1", gnt2); end
    checks++; if (rv0 !== 1'b0 || rd0 !== 32'h0) begin errors++; $display("FAIL reset_dut0 got rv=%b rd=%h want 0/00000000", rv0, rd0); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    txn2(1'b1, MEM_WORD, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL store_latency got %0d want 3", lat); end
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL store_rsp got err=%b rd=%h want 0/00000000", er, rd); end
    txn2(1'b0, MEM_WORD, 1'b0, 32'h10, 32'h0, rd, er, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL load_latency got %0d want 3", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_word got %h want deadbeef", rd); end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat;
    txn2(1'b1, MEM_BYTE, 1'b0, 32'h13, 32'h12345680, rd, er, lat);
    txn2(1'b0, MEM_BYTE, 1'b0, 32'h13, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL load_byte_sx got %h want ffffff80", rd); end
    txn2(1'b0, MEM_BYTE, 1'b1, 32'h13, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL load_byte_zx got %h want 00000080", rd); end
    txn2(1'b0, MEM_WORD, 1'b0, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h80ADBEEF) begin errors++; $display("FAIL word_after_byte got %h want 80adbeef", rd); end
    txn2(1'b0, MEM_HALF, 1'b0, 32'h12, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFF80AD) begin errors++; $display("FAIL load_half_sx got %h want ffff80ad", rd); end
    txn2(1'b0, MEM_BYTE, 1'b0, 32'h11, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFFFBE) begin errors++; $display("FAIL load_byte1_sx got %h want ffffffbe", rd); end
  endtask

  task automatic test_back_to_back();
    req0 = 1'b1; wr0 = 1'b1; size0 = MEM_WORD; zx0 = 1'b0; addr0 = 32'h20; wdata0 = 32'hAAAA5555;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL b2b_gnt_idle got %b want 1", gnt0); end
    @(posedge clk); #1;
    checks++; if (rv0 !== 1'b1 || gnt0 !== 1'b1) begin errors++; $display("FAIL b2b_rsp1 got rv=%b gnt=%b want 1/1", rv0, gnt0); end
    size0 = MEM_HALF; addr0 = 32'h22; wdata0 = 32'hFFFF1234;
    @(posedge clk); #1;
    checks++; if (rv0 !== 1'b1 || rd0 !== 32'h0 || gnt0 !== 1'b1) begin errors++; $display("FAIL b2b_rsp2 got rv=%b rd=%h gnt=%b want 1/00000000/1", rv0, rd0, gnt0); end
    wr0 = 1'b0;
    @(posedge clk); #1;
    checks++; if (rv0 !== 1'b1 || rd0 !== 32'h00001234) begin errors++; $display("FAIL b2b_load_half got rv=%b rd=%h want 1/00001234", rv0, rd0); end
    size0 = MEM_WORD; addr0 = 32'h20;
    @(posedge clk); #1;
    checks++; if (rv0 !== 1'b1 || rd0 !== 32'h12345555) begin errors++; $display("FAIL b2b_load_word got rv=%b rd=%h want 1/12345555", rv0, rd0); end
    req0 = 1'b0;
    @(posedge clk); #1;
    checks++; if (rv0 !== 1'b0 || rd0 !== 32'h12345555 || gnt0 !== 1'b1) begin errors++; $display("FAIL b2b_hold got rv=%b rd=%h gnt=%b want 0/12345555/1", rv0, rd0, gnt0); end
  endtask

  task automatic test_hold();
    logic [31:0] rd; logic er; int lat; int n = 0;
    req2 = 1'b1; wr2 = 1'b1; size2 = MEM_WORD; zx2 = 1'b0; addr2 = 32'h30; wdata2 = 32'h11111111;
    while (!gnt2 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    addr2 = 32'h34; wdata2 = 32'h22222222;
    checks++; if (gnt2 !== 1'b0 || rv2 !== 1'b0) begin errors++; $display("FAIL hold_wait1 got gnt=%b rv=%b want 0/0", gnt2, rv2); end
    @(posedge clk); #1;
    checks++; if (gnt2 !== 1'b0 || rv2 !== 1'b0) begin errors++; $display("FAIL hold_wait2 got gnt=%b rv=%b want 0/0", gnt2, rv2); end
    @(posedge clk); #1;
    checks++; if (gnt2 !== 1'b1 || rv2 !== 1'b1) begin errors++; $display("FAIL hold_resp got gnt=%b rv=%b want 1/1", gnt2, rv2); end
    @(posedge clk); #1;
    req2 = 1'b0;
    checks++; if (gnt2 !== 1'b0 || rv2 !== 1'b0) begin errors++; $display("FAIL hold_second_accept got gnt=%b rv=%b want 0/0", gnt2, rv2); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (rv2 !== 1'b1) begin errors++; $display("FAIL hold_second_rsp got %b want 1", rv2); end
    txn2(1'b0, MEM_WORD, 1'b0, 32'h30, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL hold_first_data got %h want 11111111", rd); end
    txn2(1'b0, MEM_WORD, 1'b0, 32'h34, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h22222222) begin errors++; $display("FAIL hold_second_data got %h want 22222222", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; int n = 0; int seen = 0;
    txn2(1'b1, MEM_WORD, 1'b0, 32'h40, 32'hCAFEF00D, rd, er, lat);
    req2 = 1'b1; wr2 = 1'b1; size2 = MEM_WORD; addr2 = 32'h40; wdata2 = 32'hBAD0BAD0;
    while (!gnt2 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req2 = 1'b0;
    reset_n = 1'b0;
    #3;
    checks++; if (rv2 !== 1'b0 || gnt2 !== 1'b1) begin errors++; $display("FAIL midreset_state got rv=%b gnt=%b want 0/1", rv2, gnt2); end
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; if (rv2) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_rsp got %0d pulses want 0", seen); end
    txn2(1'b0, MEM_WORD, 1'b0, 32'h40, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL midreset_data got %h want cafef00d", rd); end
  endtask

  task automatic test_access_check();
    logic [31:0] rd; logic er; int lat;
    logic        exp_err;
    logic [31:0] exp_w40, exp_oor, exp_mis;
`ifdef DMEM_ACCESS_CHECK_EN
    exp_err = 1'b1; exp_w40 = 32'hCAFEF00D; exp_oor = 32'h0; exp_mis = 32'h0;
`else
    exp_err = 1'b0; exp_w40 = 32'h5A5A5A5A; exp_oor = 32'h0BADC0DE; exp_mis = 32'h000080AD;
`endif
    txn2(1'b1, MEM_WORD, 1'b0, 32'h0, 32'h0BADC0DE, rd, er, lat);
    txn2(1'b1, MEM_WORD, 1'b0, 32'h41, 32'h5A5A5A5A, rd, er, lat);
    checks++; if (er !== exp_err || lat !== 3) begin errors++; $display("FAIL mis_store got err=%b lat=%0d want %b/3", er, lat, exp_err); end
    txn2(1'b0, MEM_WORD, 1'b0, 32'h40, 32'h0, rd, er, lat);
    checks++; if (rd !== exp_w40 || er !== 1'b0) begin errors++; $display("FAIL mis_store_effect got rd=%h err=%b want %h/0", rd, er, exp_w40); end
    txn2(1'b0, MEM_WORD, 1'b0, 32'h100, 32'h0, rd, er, lat);
    checks++; if (rd !== exp_oor || er !== exp_err) begin errors++; $display("FAIL oor_load got rd=%h err=%b want %h/%b", rd, er, exp_oor, exp_err); end
    txn2(1'b0, MEM_HALF, 1'b1, 32'h13, 32'h0, rd, er, lat);
    checks++; if (rd !== exp_mis || er !== exp_err) begin errors++; $display("FAIL mis_half_load got rd=%h err=%b want %h/%b", rd, er, exp_mis, exp_err); end
    @(posedge clk); #1;
    checks++; if (rv2 !== 1'b0 || err2 !== 1'b0) begin errors++; $display("FAIL err_pulse got rv=%b err=%b want 0/0", rv2, err2); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    req2 = 1'b0; wr2 = 1'b0; size2 = MEM_WORD; zx2 = 1'b0; addr2 = '0; wdata2 = '0;
    req0 = 1'b0; wr0 = 1'b0; size0 = MEM_WORD; zx0 = 1'b0; addr0 = '0; wdata0 = '0;
    #12;
    test_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    test_word();
    test_byte();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_access_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
